// File: rtl/udma_cfg_pkg.sv
// uDMA channel map constants, decoded event payload and channel-to-peripheral decode.
package udma_cfg_pkg;

    localparam int unsigned N_TX_LIN_CHANNELS = 6;
    localparam int unsigned N_RX_LIN_CHANNELS = 5;

    // Peripheral IDs
    localparam logic [4:0] PER_ID_UART    = 5'd0;
    localparam logic [4:0] PER_ID_QSPIM   = 5'd1;
    localparam logic [4:0] PER_ID_I2C     = 5'd2;
    localparam logic [4:0] PER_ID_CPI     = 5'd3;
    localparam logic [4:0] PER_ID_HYPER   = 5'd4;
    localparam logic [4:0] PER_ID_INVALID = 5'd31;

    // TX linear channel assignment
    localparam logic [4:0] TX_CH_UART      = 5'd0;
    localparam logic [4:0] TX_CH_QSPIM     = 5'd1;
    localparam logic [4:0] TX_CH_QSPIM_CMD = 5'd2;
    localparam logic [4:0] TX_CH_I2C       = 5'd3;
    localparam logic [4:0] TX_CH_I2C_CMD   = 5'd4;
    localparam logic [4:0] TX_CH_HYPER     = 5'd5;

    // RX linear channel assignment
    localparam logic [4:0] RX_CH_UART  = 5'd0;
    localparam logic [4:0] RX_CH_QSPIM = 5'd1;
    localparam logic [4:0] RX_CH_I2C   = 5'd2;
    localparam logic [4:0] RX_CH_CPI   = 5'd3;
    localparam logic [4:0] RX_CH_HYPER = 5'd4;

    // Number of HYPER channels per direction
    localparam logic [4:0] N_HYPER_CH = 5'd1;

    typedef struct packed {
        logic [4:0] per_id;
        logic [4:0] ch_id;
        logic       dir;
        logic       cmd;
    } udma_evt_t;

    // Inverse of the peripheral-to-channel map; dir=1 selects the TX table.
    function automatic udma_evt_t ch2evt(input logic [4:0] idx, input logic dir);
        udma_evt_t evt;
        evt.per_id = PER_ID_INVALID;
        evt.ch_id  = idx;
        evt.dir    = dir;
        evt.cmd    = 1'b0;
        if (dir) begin
            case (idx)
                TX_CH_UART:      evt.per_id = PER_ID_UART;
                TX_CH_QSPIM:     evt.per_id = PER_ID_QSPIM;
                TX_CH_QSPIM_CMD: begin
                    evt.per_id = PER_ID_QSPIM;
                    evt.cmd    = 1'b1;
                end
                TX_CH_I2C:       evt.per_id = PER_ID_I2C;
                TX_CH_I2C_CMD:   begin
                    evt.per_id = PER_ID_I2C;
                    evt.cmd    = 1'b1;
                end
                default: begin
                    if (idx >= TX_CH_HYPER && idx < TX_CH_HYPER + N_HYPER_CH)
                        evt.per_id = PER_ID_HYPER + 5'd1 + (idx - TX_CH_HYPER);
                end
            endcase
        end else begin
            case (idx)
                RX_CH_UART:  evt.per_id = PER_ID_UART;
                RX_CH_QSPIM: evt.per_id = PER_ID_QSPIM;
                RX_CH_I2C:   evt.per_id = PER_ID_I2C;
                RX_CH_CPI:   evt.per_id = PER_ID_CPI;
                default: begin
                    if (idx >= RX_CH_HYPER && idx < RX_CH_HYPER + N_HYPER_CH)
                        evt.per_id = PER_ID_HYPER + 5'd1 + (idx - RX_CH_HYPER);
                end
            endcase
        end
        return evt;
    endfunction

endpackage

// File: rtl/udma_evt_fifo.sv
// Small FIFO of decoded events with registered full/empty and same-cycle push/pop.
module udma_evt_fifo
    import udma_cfg_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      push_i,
    input  udma_evt_t data_i,
    input  logic      pop_i,
    output udma_evt_t data_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    udma_evt_t     mem_q [DEPTH];
    udma_evt_t     mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          push_ok, pop_ok;

    // Next-state: a pop frees the slot a push may refill in the same cycle.
    always_comb begin
        push_ok  = push_i & (~full_q | pop_i);
        pop_ok   = pop_i & ~empty_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        full_d  = (cnt_d == CW'(DEPTH));
        empty_d = (cnt_d == '0);
    end

    // State registers; storage is cleared so the head reads zero out of reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/udma_ch_evt_decoder.sv
// Collects uDMA channel done pulses, arbitrates round-robin, decodes and queues events.
module udma_ch_evt_decoder
    import udma_cfg_pkg::*;
#(
    parameter int unsigned N_TX       = N_TX_LIN_CHANNELS,
    parameter int unsigned N_RX       = N_RX_LIN_CHANNELS,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N_TX-1:0] tx_done_i,
    input  logic [N_RX-1:0] rx_done_i,
    input  logic            clr_i,
    output logic            evt_valid_o,
    input  logic            evt_ready_i,
    output logic [4:0]      evt_per_id_o,
    output logic [4:0]      evt_ch_id_o,
    output logic            evt_dir_o,
    output logic            evt_cmd_o,
    output logic [7:0]      drop_cnt_o
);

    localparam int unsigned NCH = N_TX + N_RX;
    localparam int unsigned PW  = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0] req;
    logic [NCH-1:0] pending_q, pending_d;
    logic [NCH-1:0] gnt_vec;
    logic [NCH-1:0] drop_vec;
    logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [7:0]     drop_cnt_q, drop_cnt_d;
    logic           gnt_valid;
    int unsigned    gnt_idx;
    logic           fifo_full, fifo_empty, fifo_pop, can_grant;
    udma_evt_t      push_evt, head_evt;

    assign req       = {rx_done_i, tx_done_i};
    assign fifo_pop  = ~fifo_empty & evt_ready_i;
    assign can_grant = ~fifo_full | fifo_pop;

    // Round-robin search over pending bits starting at rr_ptr.
    always_comb begin
        int unsigned cand;
        gnt_valid = 1'b0;
        gnt_idx   = 0;
        cand      = 0;
        for (int unsigned off = 0; off < NCH; off++) begin
            cand = 32'(rr_ptr_q) + off;
            if (cand >= NCH) cand = cand - NCH;
            if (!gnt_valid && can_grant && pending_q[PW'(cand)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Grant side effects: decode, pointer advance, pending update, drop detection.
    always_comb begin
        gnt_vec  = '0;
        push_evt = '0;
        rr_ptr_d = rr_ptr_q;
        if (gnt_valid) begin
            gnt_vec[PW'(gnt_idx)] = 1'b1;
            if (gnt_idx < N_TX) push_evt = ch2evt(5'(gnt_idx), 1'b1);
            else                push_evt = ch2evt(5'(gnt_idx - N_TX), 1'b0);
            rr_ptr_d = (gnt_idx == NCH - 1) ? '0 : PW'(gnt_idx + 1);
        end
        // A new pulse on the bit being granted re-arms it instead of dropping.
        pending_d = (pending_q & ~gnt_vec) | req;
        drop_vec  = req & pending_q & ~gnt_vec;
    end

    // Saturating drop counter; clear takes priority over same-cycle drops.
    always_comb begin
        logic [15:0] sum;
        sum = 16'(drop_cnt_q);
        for (int unsigned i = 0; i < NCH; i++) begin
            sum = sum + 16'(drop_vec[i]);
        end
        if (clr_i)              drop_cnt_d = '0;
        else if (sum > 16'd255) drop_cnt_d = 8'd255;
        else                    drop_cnt_d = sum[7:0];
    end

    // State registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q  <= '0;
            rr_ptr_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            pending_q  <= pending_d;
            rr_ptr_q   <= rr_ptr_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    udma_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (gnt_valid),
        .data_i  (push_evt),
        .pop_i   (fifo_pop),
        .data_o  (head_evt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign evt_valid_o  = ~fifo_empty;
    assign evt_per_id_o = head_evt.per_id;
    assign evt_ch_id_o  = head_evt.ch_id;
    assign evt_dir_o    = head_evt.dir;
    assign evt_cmd_o    = head_evt.cmd;
    assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_udma_ch_evt_decoder.sv
// Self-checking bench for udma_ch_evt_decoder: vector table, directed corners, random vs. model.
module tb_udma_ch_evt_decoder;

    localparam int NTX   = 6;
    localparam int NRX   = 5;
    localparam int NCH   = NTX + NRX;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0] per;
        logic [4:0] ch;
        logic       dir;
        logic       cmd;
    } ev_t;

    typedef struct {
        logic       rst;
        logic [5:0] tx;
        logic [4:0] rx;
        logic       rdy;
        logic       clr;
        logic       ev;
        logic [4:0] eper;
        logic [4:0] ech;
        logic       edir;
        logic       ecmd;
        logic [7:0] edrop;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_i, clr_i, evt_ready_i;
    logic [5:0] tx_done_i;
    logic [4:0] rx_done_i;
    logic       evt_valid_o;
    logic [4:0] evt_per_id_o, evt_ch_id_o;
    logic       evt_dir_o, evt_cmd_o;
    logic [7:0] drop_cnt_o;

    int checks = 0;
    int errors = 0;
    int ord[16];
    vec_t vt[13];

    // Reference model state
    bit  m_pend[NCH];
    int  m_rr;
    ev_t mq[$];
    int  m_drop;

    always #5 clk = ~clk;

    udma_ch_evt_decoder #(
        .N_TX       (NTX),
        .N_RX       (NRX),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .tx_done_i    (tx_done_i),
        .rx_done_i    (rx_done_i),
        .clr_i        (clr_i),
        .evt_valid_o  (evt_valid_o),
        .evt_ready_i  (evt_ready_i),
        .evt_per_id_o (evt_per_id_o),
        .evt_ch_id_o  (evt_ch_id_o),
        .evt_dir_o    (evt_dir_o),
        .evt_cmd_o    (evt_cmd_o),
        .drop_cnt_o   (drop_cnt_o)
    );

    // Channel map written out as a lookup table of the expected decode.
    function automatic ev_t ref_evt(input int idx);
        ev_t e;
        e.cmd = 1'b0;
        if (idx < NTX) begin
            e.dir = 1'b1;
            e.ch  = 5'(idx);
            case (idx)
                0: e.per = 5'd0;
                1: e.per = 5'd1;
                2: begin e.per = 5'd1; e.cmd = 1'b1; end
                3: e.per = 5'd2;
                4: begin e.per = 5'd2; e.cmd = 1'b1; end
                5: e.per = 5'd5;
                default: e.per = 5'd31;
            endcase
        end else begin
            e.dir = 1'b0;
            e.ch  = 5'(idx - NTX);
            case (idx - NTX)
                0: e.per = 5'd0;
                1: e.per = 5'd1;
                2: e.per = 5'd2;
                3: e.per = 5'd3;
                4: e.per = 5'd5;
                default: e.per = 5'd31;
            endcase
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [5:0] tx, input logic [4:0] rx,
                         input logic rdy, input logic c);
        rst_i       = r;
        tx_done_i   = tx;
        rx_done_i   = rx;
        evt_ready_i = rdy;
        clr_i       = c;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_fields(input string name, input ev_t e);
        chk({name, ".per_id"}, int'(evt_per_id_o), int'(e.per));
        chk({name, ".ch_id"},  int'(evt_ch_id_o),  int'(e.ch));
        chk({name, ".dir"},    int'(evt_dir_o),    int'(e.dir));
        chk({name, ".cmd"},    int'(evt_cmd_o),    int'(e.cmd));
    endtask

    task automatic do_reset();
        drive(1'b1, '0, '0, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    // Pops with ready=1 and expects channel indices ord[0..n-1] in order, then silence.
    task automatic drain_expect(input string name, input int n);
        int got;
        got = 0;
        evt_ready_i = 1'b1;
        for (int c = 0; c < 40 && got < n; c++) begin
            if (evt_valid_o) begin
                chk(.name($sformatf("%s[%0d].valid", name, got)), .act(1), .exp(1));
                chk_fields($sformatf("%s[%0d]", name, got), ref_evt(ord[got]));
                got++;
            end
            tick();
        end
        chk({name, ".count"}, got, n);
        tick();
        tick();
        chk({name, ".no_extra"}, int'(evt_valid_o), 0);
    endtask

    task automatic model_step(input logic r, input logic [5:0] tx, input logic [4:0] rx,
                              input logic rdy, input logic c);
        bit req[NCH];
        bit pop, room;
        int g, nd, idx;
        if (r) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_rr   = 0;
            mq.delete();
            m_drop = 0;
            return;
        end
        for (int i = 0; i < NTX; i++) req[i] = tx[i];
        for (int i = 0; i < NRX; i++) req[NTX + i] = rx[i];
        pop  = (mq.size() > 0) && rdy;
        room = (mq.size() < DEPTH) || pop;
        g    = -1;
        if (room) begin
            for (int k = 0; k < NCH; k++) begin
                idx = (m_rr + k) % NCH;
                if (m_pend[idx]) begin
                    g = idx;
                    break;
                end
            end
        end
        nd = 0;
        for (int i = 0; i < NCH; i++) begin
            if (req[i] && m_pend[i] && i != g) nd++;
        end
        for (int i = 0; i < NCH; i++) begin
            m_pend[i] = req[i] || (m_pend[i] && i != g);
        end
        if (pop) void'(mq.pop_front());
        if (g >= 0) begin
            mq.push_back(ref_evt(g));
            m_rr = (g + 1) % NCH;
        end
        if (c) m_drop = 0;
        else   m_drop = (m_drop + nd > 255) ? 255 : m_drop + nd;
    endtask

    initial begin
        drive(1'b1, '0, '0, 1'b1, 1'b0);

        // ---- vector table: single tx2 event, tx5+rx4 ordering, pointer wrap ----
        vt[0]  = '{1'b1, 6'h00, 5'h00, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 8'd0};
        vt[1]  = '{1'b0, 6'h04, 5'h00, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 8'd0};
        vt[2]  = '{1'b0, 6'h00, 5'h00, 1'b1, 1'b0, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 8'd0};
        vt[3]  = '{1'b0, 6'h00, 5'h00, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 8'd0};
        vt[4]  = '{1'b1, 6'h00, 5'h00, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 8'd0};
        vt[5]  = '{1'b0, 6'h20, 5'h10, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 8'd0};
        vt[6]  = '{1'b0, 6'h00, 5'h00, 1'b1, 1'b0, 1'b1, 5'd5, 5'd5, 1'b1, 1'b0, 8'd0};
        vt[7]  = '{1'b0, 6'h00, 5'h00, 1'b1, 1'b0, 1'b1, 5'd5, 5'd4, 1'b0, 1'b0, 8'd0};
        vt[8]  = '{1'b0, 6'h00, 5'h00, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 8'd0};
        vt[9]  = '{1'b0, 6'h01, 5'h10, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 8'd0};
        vt[10] = '{1'b0, 6'h00, 5'h00, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 8'd0};
        vt[11] = '{1'b0, 6'h00, 5'h00, 1'b1, 1'b0, 1'b1, 5'd5, 5'd4, 1'b0, 1'b0, 8'd0};
        vt[12] = '{1'b0, 6'h00, 5'h00, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 8'd0};

        for (int i = 0; i < 13; i++) begin
            ev_t e;
            drive(vt[i].rst, vt[i].tx, vt[i].rx, vt[i].rdy, vt[i].clr);
            tick();
            chk($sformatf("vec%0d.valid", i), int'(evt_valid_o), int'(vt[i].ev));
            if (vt[i].ev || vt[i].rst) begin
                e.per = vt[i].eper;
                e.ch  = vt[i].ech;
                e.dir = vt[i].edir;
                e.cmd = vt[i].ecmd;
                chk_fields($sformatf("vec%0d", i), e);
            end
            chk($sformatf("vec%0d.drop", i), int'(drop_cnt_o), int'(vt[i].edrop));
        end

        // ---- all 11 channels with ready low, then drain in index order ----
        do_reset();
        drive(1'b0, 6'h3F, 5'h1F, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        chk("all11.valid", int'(evt_valid_o), 1);
        chk_fields("all11.head", ref_evt(0));
        chk("all11.drop", int'(drop_cnt_o), 0);
        for (int i = 0; i < NCH; i++) ord[i] = i;
        drain_expect("all11", NCH);

        // ---- drop counting, saturation, clear priority ----
        do_reset();
        drive(1'b0, 6'h1E, 5'h00, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        drive(1'b0, 6'h01, 5'h00, 1'b0, 1'b0);
        tick();
        chk("drop.none_yet", int'(drop_cnt_o), 0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        chk("drop.first", int'(drop_cnt_o), 1);
        for (int i = 0; i < 300; i++) begin
            drive(1'b0, 6'h01, 5'h00, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        chk("drop.saturate", int'(drop_cnt_o), 255);
        drive(1'b0, 6'h01, 5'h00, 1'b0, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        chk("drop.clr_wins", int'(drop_cnt_o), 0);
        drive(1'b0, 6'h01, 5'h00, 1'b0, 1'b0);
        tick();
        chk("drop.after_clr", int'(drop_cnt_o), 1);
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        chk("drop.clr", int'(drop_cnt_o), 0);
        ord[0] = 1; ord[1] = 2; ord[2] = 3; ord[3] = 4; ord[4] = 0;
        drain_expect("drop.drain", 5);

        // ---- pulse arriving in the same cycle its pending bit is granted ----
        do_reset();
        drive(1'b0, 6'h08, 5'h00, 1'b1, 1'b0);
        tick();
        drive(1'b0, 6'h08, 5'h00, 1'b1, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        ord[0] = 3; ord[1] = 3;
        drain_expect("regrant", 2);
        chk("regrant.drop", int'(drop_cnt_o), 0);

        // ---- reset with 3 queued and 2 pending ----
        do_reset();
        drive(1'b0, 6'h1F, 5'h00, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        chk("midrst.before", int'(evt_valid_o), 1);
        drive(1'b1, '0, '0, 1'b0, 1'b0);
        tick();
        chk("midrst.valid", int'(evt_valid_o), 0);
        chk("midrst.drop", int'(drop_cnt_o), 0);
        chk_fields("midrst", '0);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("midrst.stale%0d", i), int'(evt_valid_o), 0);
        end

        // ---- randomized traffic against the reference model ----
        for (int c = 0; c < 3000; c++) begin
            logic       r, rdy, cl;
            logic [5:0] tx;
            logic [4:0] rx;
            int         phase;
            phase = (c / 500) % 3;
            r     = (c == 0) || ($urandom_range(0, 799) == 0);
            tx    = 6'($urandom);
            rx    = 5'($urandom);
            if (phase == 0) begin
                tx  = tx & 6'($urandom) & 6'($urandom);
                rx  = rx & 5'($urandom) & 5'($urandom);
                rdy = ($urandom_range(0, 3) != 0);
            end else if (phase == 1) begin
                rdy = ($urandom_range(0, 3) == 0);
            end else begin
                tx  = tx & 6'($urandom);
                rx  = rx & 5'($urandom);
                rdy = $urandom_range(0, 1) != 0;
            end
            cl = ($urandom_range(0, 63) == 0);
            drive(r, tx, rx, rdy, cl);
            model_step(r, tx, rx, rdy, cl);
            tick();
            chk($sformatf("rand%0d.valid", c), int'(evt_valid_o), (mq.size() > 0) ? 1 : 0);
            if (mq.size() > 0) chk_fields($sformatf("rand%0d", c), mq[0]);
            chk($sformatf("rand%0d.drop", c), int'(drop_cnt_o), m_drop);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
